// File: rtl/aer_bus_arbiter.sv
// ============================================================================
//  Module      : aer_bus_arbiter
//  Description : Round-robin arbiter sharing one AER bus between N_REQ event
//                senders. Grants one sender, runs a four-phase REQ/ACK
//                handshake with the receiver, then a four-phase handshake back
//                to the winning sender. Handshake waits are bounded by TIMEOUT.
//                Optional macro AER_SYNC_EN inserts 2-flop synchronizers on
//                req and aer_ack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aer_bus_arbiter #(
    parameter int N_REQ     = 8,
    parameter int ADDR_W    = 3,
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  ack_out,
    output logic [ADDR_W-1:0] aer_addr,
    output logic              aer_req,
    input  logic              aer_ack,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0]  c_IDLE       = 3'd0;
    localparam logic [2:0]  c_SETUP      = 3'd1;
    localparam logic [2:0]  c_WAIT_HI    = 3'd2;
    localparam logic [2:0]  c_WAIT_LO    = 3'd3;
    localparam logic [2:0]  c_RELEASE    = 3'd4;
    localparam logic [15:0] c_SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] c_TMO_LAST   = 16'(TIMEOUT - 1);

    logic [N_REQ-1:0]  w_req;
    logic              w_ack;

    logic [2:0]        r_state,   w_state_nxt;
    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic [ADDR_W-1:0] r_ptr,     w_ptr_nxt;
    logic [15:0]       r_cnt,     w_cnt_nxt;
    logic              r_aer_req, w_aer_req_nxt;
    logic [N_REQ-1:0]  r_ack_out, w_ack_out_nxt;
    logic              r_err,     w_err_nxt;
    logic              r_busy,    w_busy_nxt;

    logic [ADDR_W-1:0] w_hi_win, w_lo_win, w_win;
    logic              w_hi_any, w_lo_any;
    logic [N_REQ-1:0]  w_grant_onehot;

`ifdef AER_SYNC_EN
    logic [N_REQ-1:0] r_req_s1, r_req_s2;
    logic             r_ack_s1, r_ack_s2;

    // Two-flop synchronizers for the asynchronous sender and receiver inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_s1 <= '0;
            r_req_s2 <= '0;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_req_s1 <= req;
            r_req_s2 <= r_req_s1;
            r_ack_s1 <= aer_ack;
            r_ack_s2 <= r_ack_s1;
        end
    end

    assign w_req = r_req_s2;
    assign w_ack = r_ack_s2;
`else
    assign w_req = req;
    assign w_ack = aer_ack;
`endif

    // Round-robin winner: lowest set bit at or above ptr, else lowest set bit overall
    always_comb begin
        w_hi_win = '0;
        w_lo_win = '0;
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_lo_win = ADDR_W'(i);
                w_lo_any = 1'b1;
                if (ADDR_W'(i) >= r_ptr) begin
                    w_hi_win = ADDR_W'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
        w_win = w_hi_any ? w_hi_win : w_lo_win;
    end

    assign w_grant_onehot = N_REQ'(1) << r_addr;

    // Next-state and next-output logic of the handshake sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt + 16'd1;
        w_aer_req_nxt = r_aer_req;
        w_ack_out_nxt = r_ack_out;
        w_err_nxt     = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                if (w_lo_any) begin
                    w_addr_nxt  = w_win;
                    w_state_nxt = c_SETUP;
                end
            end
            c_SETUP: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_aer_req_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = c_WAIT_HI;
                end
            end
            c_WAIT_HI: begin
                if (w_ack) begin
                    w_aer_req_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = c_WAIT_LO;
                end else if (r_cnt == c_TMO_LAST) begin
                    // Give up on the receiver but still release the sender
                    w_err_nxt     = 1'b1;
                    w_aer_req_nxt = 1'b0;
                    w_ack_out_nxt = w_grant_onehot;
                    w_state_nxt   = c_RELEASE;
                end
            end
            c_WAIT_LO: begin
                if (!w_ack) begin
                    w_ack_out_nxt = w_grant_onehot;
                    w_state_nxt   = c_RELEASE;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_err_nxt     = 1'b1;
                    w_aer_req_nxt = 1'b0;
                    w_ack_out_nxt = w_grant_onehot;
                    w_state_nxt   = c_RELEASE;
                end
            end
            c_RELEASE: begin
                w_cnt_nxt = '0;
                // ack_out is one-hot on the winner here, so it masks req[g]
                if ((w_req & r_ack_out) == '0) begin
                    w_ack_out_nxt = '0;
                    w_ptr_nxt     = (r_addr == ADDR_W'(N_REQ - 1)) ? '0 : r_addr + 1'b1;
                    w_state_nxt   = c_IDLE;
                end
            end
            default: begin
                w_cnt_nxt     = '0;
                w_aer_req_nxt = 1'b0;
                w_ack_out_nxt = '0;
                w_state_nxt   = c_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != c_IDLE);
    end

    // State and registered outputs; reset abandons any transaction immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_addr    <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_aer_req <= 1'b0;
            r_ack_out <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_aer_req <= w_aer_req_nxt;
            r_ack_out <= w_ack_out_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign ack_out  = r_ack_out;
    assign aer_addr = r_addr;
    assign aer_req  = r_aer_req;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

`default_nettype wire
